prime_sequencer: RTL and testbench

// Produces, in ascending order, every prime p with 2 <= p <= boundary, one per valid/ready handshake.

---
 rtl/prime_sequencer.sv | 145 ++++++++++++++
 tb/tb_prime_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/prime_sequencer.sv
// prime_sequencer: emits every prime 2 <= p <= boundary in ascending order,
// one per valid/ready handshake. Primality is decided by trial division
// that uses repeated subtraction, so each clock performs one compare or one subtract.
module prime_sequencer #(
  parameter int BOUND_W = 8,
  parameter int PRIME_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BOUND_W-1:0] boundary,
  output logic [PRIME_W-1:0] prime,
  output logic               prime_valid,
  input  logic               prime_ready,
  output logic               busy,
  output logic               done
);

  // div*div is held 10 bits wide so the square never wraps for a 5-bit divisor
  localparam int SQ_W  = 10;
  localparam int DIV_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [BOUND_W-1:0] bound;
  logic [PRIME_W-1:0] cand;
  logic [PRIME_W-1:0] rem;
  logic [PRIME_W-1:0] prime_q;
  logic [DIV_W-1:0]   div;

  logic [SQ_W-1:0] div_ext;
  logic [SQ_W-1:0] div_sq;
  logic            sq_gt;
  logic            rem_ge;
  logic            rem_zero;
  logic            at_bound;
  logic            small_bound;
  logic            accept_start;

  assign div_ext      = SQ_W'(div);
  assign div_sq       = div_ext * div_ext;
  assign sq_gt        = div_sq > SQ_W'(cand);
  assign rem_ge       = rem >= PRIME_W'(div);
  assign rem_zero     = (rem == '0);
  // Comparing before incrementing lets a full-scale bound finish without wrapping cand
  assign at_bound     = (cand == PRIME_W'(bound));
  assign small_bound  = (boundary < BOUND_W'(2));
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_nxt   = state;
    prime_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        // A bound below 2 goes straight through NEXT, where cand==bound ends the sweep
        if (start) state_nxt = small_bound ? S_NEXT : S_TEST;
      end
      S_TEST: begin
        busy = 1'b1;
        if (sq_gt)         state_nxt = S_EMIT;
        else if (rem_ge)   state_nxt = S_TEST;
        else if (rem_zero) state_nxt = S_NEXT;
        else               state_nxt = S_TEST;
      end
      S_EMIT: begin
        busy        = 1'b1;
        prime_valid = 1'b1;
        if (prime_ready) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = at_bound ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = small_bound ? S_NEXT : S_TEST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Candidate, divisor, remainder, bound and output prime registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bound   <= '0;
      cand    <= '0;
      div     <= '0;
      rem     <= '0;
      prime_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept_start) begin
            bound <= boundary;
            if (small_bound) begin
              cand <= PRIME_W'(boundary);
            end else begin
              cand <= PRIME_W'(2);
              div  <= DIV_W'(2);
              rem  <= PRIME_W'(2);
            end
          end
        end
        S_TEST: begin
          if (sq_gt) begin
            prime_q <= cand;
          end else if (rem_ge) begin
            rem <= rem - PRIME_W'(div);
          end else if (!rem_zero) begin
            div <= div + DIV_W'(1);
            rem <= cand;
          end
        end
        S_NEXT: begin
          if (!at_bound) begin
            cand <= cand + PRIME_W'(1);
            div  <= DIV_W'(2);
            rem  <= cand + PRIME_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign prime = prime_q;

endmodule

// File: tb/tb_prime_sequencer.sv
// Self-checking bench for prime_sequencer: each sweep is compared with a
// list of primes built by plain modulo trial division.
module tb_prime_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] boundary = '0;
  logic [8:0] prime;
  logic       prime_valid;
  logic       prime_ready = 1'b0;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  prime_sequencer #(.BOUND_W(8), .PRIME_W(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .boundary    (boundary),
    .prime       (prime),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // One full sweep from IDLE/DONE; optionally injects a start while busy
  task automatic run_sweep(input int b, input bit stall, input int inj_cyc,
                           input int inj_b, input string name,
                           output int n_acc, output int last_acc);
    int  exp_q[$];
    int  cyc;
    int  first_valid;
    int  held_val;
    bit  holding;
    for (int n = 2; n <= b; n++)
      if (is_prime(n)) exp_q.push_back(n);
    n_acc       = 0;
    last_acc    = -1;
    first_valid = -1;
    held_val    = 0;
    holding     = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    boundary    = 8'(b);
    prime_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({name, " busy_after_start"}, int'(busy), 1);
    check({name, " done_cleared"}, int'(done), 0);
    while (!done && cyc < 60000) begin
      if (prime_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (holding) check({name, " stable"}, int'(prime), held_val);
        held_val    = int'(prime);
        prime_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prime_ready) begin
          if (n_acc < exp_q.size())
            check({name, " prime"}, int'(prime), exp_q[n_acc]);
          else
            check({name, " extra_prime"}, n_acc + 1, exp_q.size());
          last_acc = int'(prime);
          n_acc++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
        end
      end else begin
        prime_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        holding     = 1'b0;
      end
      if (cyc == inj_cyc) begin
        start    = 1'b1;
        boundary = 8'(inj_b);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start       = 1'b0;
    prime_ready = 1'b0;
    check({name, " finished_in_budget"}, int'(cyc < 60000), 1);
    check({name, " count"}, n_acc, exp_q.size());
    check({name, " busy_end"}, int'(busy), 0);
    check({name, " valid_end"}, int'(prime_valid), 0);
    if (b >= 2) check({name, " first_latency"}, first_valid, 2);
    else        check({name, " done_latency"}, cyc, 2);
    repeat (3) @(negedge clk);
    check({name, " done_sticky"}, int'(done), 1);
  endtask

  initial begin
    int n_acc, last_acc, rb, guard;

    #12;
    check("reset prime", int'(prime), 0);
    check("reset valid", int'(prime_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(10, 1'b0, -1, 0, "b10", n_acc, last_acc);
    check("b10 last", last_acc, 7);
    run_sweep(1, 1'b0, -1, 0, "b1", n_acc, last_acc);
    check("b1 count", n_acc, 0);
    run_sweep(0, 1'b1, -1, 0, "b0", n_acc, last_acc);
    check("b0 count", n_acc, 0);
    run_sweep(2, 1'b0, -1, 0, "b2", n_acc, last_acc);
    check("b2 last", last_acc, 2);
    run_sweep(4, 1'b0, -1, 0, "b4", n_acc, last_acc);
    check("b4 last", last_acc, 3);
    run_sweep(255, 1'b1, -1, 0, "b255", n_acc, last_acc);
    check("b255 count", n_acc, 54);
    check("b255 last", last_acc, 251);

    // Asynchronous reset while a prime of 5 is waiting for the consumer
    @(negedge clk);
    start       = 1'b1;
    boundary    = 8'd20;
    prime_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(prime_valid && prime == 9'd5) && guard < 5000) begin
      prime_ready = prime_valid ? 1'b1 : 1'b0;
      @(negedge clk);
      prime_ready = 1'b0;
      guard++;
    end
    prime_ready = 1'b0;
    check("rst reached_5", int'(guard < 5000), 1);
    @(negedge clk);
    check("rst held_valid", int'(prime_valid), 1);
    check("rst held_value", int'(prime), 5);
    #2 rst_n = 1'b0;
    #1;
    check("rst async prime", int'(prime), 0);
    check("rst async valid", int'(prime_valid), 0);
    check("rst async busy", int'(busy), 0);
    check("rst async done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(7, 1'b0, -1, 0, "b7_after_rst", n_acc, last_acc);
    check("b7 last", last_acc, 7);

    run_sweep(50, 1'b0, 30, 20, "b50_ignore_start", n_acc, last_acc);
    check("b50 last", last_acc, 47);
    run_sweep(13, 1'b1, -1, 0, "b13_from_done", n_acc, last_acc);
    check("b13 last", last_acc, 13);

    for (int i = 0; i < 3; i++) begin
      rb = int'($urandom_range(0, 60));
      run_sweep(rb, 1'b1, -1, 0, $sformatf("rand%0d_b%0d", i, rb), n_acc, last_acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
